// File: rtl/unidade_de_controle.sv
// Multi-cycle control unit: 2-bit step counter, instruction register and per-step strobe decode.
// Optional feature: define UC_XOR_EN to make opcode 110 a 4-step ALU xor (otherwise it is a nop).
module unidade_de_controle (
  input  logic        clock,
  input  logic        Resetn,
  input  logic [15:0] iin,
  output logic [1:0]  Tstep,
  output logic [2:0]  OpSelect,
  output logic        Aenable,
  output logic        Renable,
  output logic        Clear,
  output logic        r0Enable,
  output logic        r1Enable,
  output logic        r2Enable,
  output logic        r3Enable,
  output logic        r4Enable,
  output logic        r5Enable,
  output logic        r6Enable,
  output logic        r7Enable,
  output logic [2:0]  regNumSelect,
  output logic        Rselect,
  output logic        Iselect,
  output logic [9:0]  Imediato
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_MVI = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  step_t       step_q, step_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] op, rx, ry;
  logic       is_alu;
  logic       we;
  logic [7:0] wen;

  assign op = ir_q[15:13];
  assign rx = ir_q[12:10];
  assign ry = ir_q[9:7];

  always_comb begin
    unique case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu = 1'b1;
`ifdef UC_XOR_EN
      OP_XOR:                        is_alu = 1'b1;
`endif
      default:                       is_alu = 1'b0;
    endcase
  end

  // IR captures iin only at the edge that closes the fetch step.
  assign ir_d = (step_q == T0) ? iin : ir_q;

  always_ff @(posedge clock or posedge Resetn) begin
    if (Resetn) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  always_comb begin
    step_d       = T0;
    OpSelect     = 3'b000;
    Aenable      = 1'b0;
    Renable      = 1'b0;
    Clear        = 1'b0;
    regNumSelect = 3'b000;
    Rselect      = 1'b0;
    Iselect      = 1'b0;
    we           = 1'b0;
    unique case (step_q)
      T0: ;
      T1: begin
        if (is_alu) begin
          regNumSelect = rx;
          Aenable      = 1'b1;
        end else begin
          Clear = 1'b1;
          if (op == OP_MV) begin
            regNumSelect = ry;
            we           = 1'b1;
          end else if (op == OP_MVI) begin
            Iselect = 1'b1;
            we      = 1'b1;
          end
        end
      end
      T2: begin
        if (is_alu) begin
          regNumSelect = ry;
          OpSelect     = op;
          Renable      = 1'b1;
        end else begin
          Clear = 1'b1;
        end
      end
      T3: begin
        Clear = 1'b1;
        if (is_alu) begin
          Rselect = 1'b1;
          we      = 1'b1;
        end
      end
      default: ;
    endcase
    // Counter: back to fetch after the last step, otherwise advance.
    if (!Clear) begin
      unique case (step_q)
        T0:      step_d = T1;
        T1:      step_d = T2;
        T2:      step_d = T3;
        default: step_d = T0;
      endcase
    end
  end

  assign wen = we ? (8'b0000_0001 << rx) : 8'b0000_0000;

  assign r0Enable = wen[0];
  assign r1Enable = wen[1];
  assign r2Enable = wen[2];
  assign r3Enable = wen[3];
  assign r4Enable = wen[4];
  assign r5Enable = wen[5];
  assign r6Enable = wen[6];
  assign r7Enable = wen[7];

  assign Tstep    = step_q;
  assign Imediato = ir_q[9:0];

endmodule

// File: tb/tb_unidade_de_controle.sv
// Directed bench for unidade_de_controle: reset, nop, mv, mvi, add, or with mid-instruction reset, opcode 110.
module tb_unidade_de_controle;
  logic        clock = 1'b0;
  logic        Resetn;
  logic [15:0] iin;
  logic [1:0]  Tstep;
  logic [2:0]  OpSelect;
  logic        Aenable, Renable, Clear;
  logic        r0Enable, r1Enable, r2Enable, r3Enable;
  logic        r4Enable, r5Enable, r6Enable, r7Enable;
  logic [2:0]  regNumSelect;
  logic        Rselect, Iselect;
  logic [9:0]  Imediato;

  int n_cmp = 0;
  int n_err = 0;

  unidade_de_controle dut (
    .clock(clock), .Resetn(Resetn), .iin(iin), .Tstep(Tstep), .OpSelect(OpSelect),
    .Aenable(Aenable), .Renable(Renable), .Clear(Clear),
    .r0Enable(r0Enable), .r1Enable(r1Enable), .r2Enable(r2Enable), .r3Enable(r3Enable),
    .r4Enable(r4Enable), .r5Enable(r5Enable), .r6Enable(r6Enable), .r7Enable(r7Enable),
    .regNumSelect(regNumSelect), .Rselect(Rselect), .Iselect(Iselect), .Imediato(Imediato)
  );

  always #5 clock = ~clock;

  // {Aenable,Renable,Clear,Rselect,Iselect}
  logic [4:0] strb;
  logic [7:0] ens;
  assign strb = {Aenable, Renable, Clear, Rselect, Iselect};
  assign ens  = {r7Enable, r6Enable, r5Enable, r4Enable, r3Enable, r2Enable, r1Enable, r0Enable};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Checks the whole output set for one step.
  task automatic chk_all(input string tag, input logic [1:0] t, input logic [4:0] s,
                         input logic [7:0] e, input logic [2:0] ops, input logic [2:0] rn);
    chk({tag, ".Tstep"}, 16'(Tstep), 16'(t));
    chk({tag, ".strobes"}, 16'(strb), 16'(s));
    chk({tag, ".enables"}, 16'(ens), 16'(e));
    chk({tag, ".OpSelect"}, 16'(OpSelect), 16'(ops));
    chk({tag, ".regNum"}, 16'(regNumSelect), 16'(rn));
  endtask

  initial begin
    Resetn = 1'b1;
    iin    = 16'hE000;
    repeat (4) tick();
    chk_all("reset", 2'd0, 5'b00000, 8'h00, 3'd0, 3'd0);
    chk("reset.Imediato", 16'(Imediato), 16'd0);

    // release between edges; first edge loads IR with the nop
    @(negedge clock); Resetn = 1'b0;
    tick();
    chk_all("nop.t1", 2'd1, 5'b00100, 8'h00, 3'd0, 3'd0);
    iin = 16'hA01C;
    tick();
    chk_all("nop.t0", 2'd0, 5'b00000, 8'h00, 3'd0, 3'd0);

    // mvi R0,#28
    tick();
    chk_all("mvi0.t1", 2'd1, 5'b00101, 8'h01, 3'd0, 3'd0);
    chk("mvi0.Imediato", 16'(Imediato), 16'd28);
    iin = 16'hA40A;
    tick();
    chk("mvi0.back", 16'(Tstep), 16'd0);

    // mvi R1,#10
    tick();
    chk_all("mvi1.t1", 2'd1, 5'b00101, 8'h02, 3'd0, 3'd0);
    chk("mvi1.Imediato", 16'(Imediato), 16'd10);
    iin = 16'h0C80;
    tick();

    // mv R3,R1
    tick();
    chk_all("mv.t1", 2'd1, 5'b00100, 8'h08, 3'd0, 3'd1);
    iin = 16'h2080;
    tick();
    chk("mv.back", 16'(Tstep), 16'd0);

    // add R0,R1
    tick();
    chk_all("add.t1", 2'd1, 5'b10000, 8'h00, 3'd0, 3'd0);
    tick();
    chk_all("add.t2", 2'd2, 5'b01000, 8'h00, 3'd1, 3'd1);
    tick();
    chk_all("add.t3", 2'd3, 5'b00110, 8'h01, 3'd0, 3'd0);
    iin = 16'h8000;
    tick();
    chk_all("add.t0", 2'd0, 5'b00000, 8'h00, 3'd0, 3'd0);

    // or R0,R0, then abort with reset in step 2
    tick();
    chk_all("or.t1", 2'd1, 5'b10000, 8'h00, 3'd0, 3'd0);
    tick();
    chk_all("or.t2", 2'd2, 5'b01000, 8'h00, 3'd4, 3'd0);
    Resetn = 1'b1;
    #1;
    chk_all("or.abort", 2'd0, 5'b00000, 8'h00, 3'd0, 3'd0);
    tick();
    chk_all("or.held", 2'd0, 5'b00000, 8'h00, 3'd0, 3'd0);
    chk("or.irclr", 16'(Imediato), 16'd0);
    iin = 16'hC000;
    @(negedge clock); Resetn = 1'b0;
    #1;
    chk_all("rel.t0", 2'd0, 5'b00000, 8'h00, 3'd0, 3'd0);

    // opcode 110
    tick();
`ifdef UC_XOR_EN
    chk_all("xor.t1", 2'd1, 5'b10000, 8'h00, 3'd0, 3'd0);
    tick();
    chk_all("xor.t2", 2'd2, 5'b01000, 8'h00, 3'd6, 3'd0);
    tick();
    chk_all("xor.t3", 2'd3, 5'b00110, 8'h01, 3'd0, 3'd0);
`else
    chk_all("op6.t1", 2'd1, 5'b00100, 8'h00, 3'd0, 3'd0);
`endif
    iin = 16'hE000;
    tick();
    chk("op6.back", 16'(Tstep), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
